// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcode values and FSM state encoding.
package alu_seq_pkg;

    // Instruction opcodes as presented on the instruction channel
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Sequencer states: accept, drive the ALU, commit the result
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Instruction channel between the instruction source (master) and the
// ALU sequencer (slave): valid/ready handshake plus the decoded fields.
interface alu_seq_if #(
    parameter int AW = 2
);

    logic          instr_valid;
    logic          instr_ready;
    logic [1:0]    instr_op;
    logic [AW-1:0] instr_srca;
    logic [AW-1:0] instr_srcb;
    logic [AW-1:0] instr_dst;

    // Instruction source side
    modport master (
        output instr_valid,
        output instr_op,
        output instr_srca,
        output instr_srcb,
        output instr_dst,
        input  instr_ready
    );

    // Sequencer side
    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_srca,
        input  instr_srcb,
        input  instr_dst,
        output instr_ready
    );

endinterface

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: NREG x WIDTH, async active-low reset,
// two operand read ports and one debug read port (all combinational).
// The write side takes a writeback and a direct load in the same cycle;
// when both target the same entry the writeback wins and the load is dropped.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data
);

    logic [WIDTH-1:0] mem [NREG];

    // Per-entry write select: writeback first, then direct load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_en && (wb_addr == AW'(i))) begin
                    mem[i] <= wb_data;
                end else if (ld_en && (ld_addr == AW'(i))) begin
                    mem[i] <= ld_data;
                end
            end
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts 2-operand instructions, reads operands from its
// register file, drives an external registered 4-bit ALU for one cycle, then
// commits the ALU result and carry/zero flags on the following cycle.
// Optional feature macro: ALU_SEQ_PIPE_EN -- accept the next instruction in
// the writeback cycle and forward the retiring result to its operands.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clock,
    input  logic             reset_n,
    alu_seq_if.slave         instr,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_enable,
    output logic             alu_op_bit0,
    output logic             alu_op_bit1,
    input  logic [WIDTH-1:0] alu_rezult,
    input  logic             alu_carry,
    input  logic             alu_z,
    output logic             done,
    output logic             flag_c,
    output logic             flag_z,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             issue;
    logic [1:0]       op_q;
    logic [AW-1:0]    srca_q;
    logic [AW-1:0]    srcb_q;
    logic [AW-1:0]    dst_q;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state control outputs
    always_comb begin
        state_nxt          = state;
        instr.instr_ready  = 1'b0;
        alu_enable         = 1'b0;
        done               = 1'b0;
        case (state)
            S_IDLE: begin
                instr.instr_ready = 1'b1;
                if (instr.instr_valid) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                alu_enable = 1'b1;
                state_nxt  = S_WB;
            end
            S_WB: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
`ifdef ALU_SEQ_PIPE_EN
                instr.instr_ready = 1'b1;
                if (instr.instr_valid) begin
                    state_nxt = S_ISSUE;
                end
`endif
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign accept = instr.instr_valid & instr.instr_ready;
    assign issue  = (state == S_ISSUE);

    // Capture the instruction fields on the accept edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            srca_q <= '0;
            srcb_q <= '0;
            dst_q  <= '0;
        end else if (accept) begin
            op_q   <= instr.instr_op;
            srca_q <= instr.instr_srca;
            srcb_q <= instr.instr_srcb;
            dst_q  <= instr.instr_dst;
        end
    end

    // Remember whether an operand depends on the instruction retiring at accept time
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fwd_a <= 1'b0;
            fwd_b <= 1'b0;
        end else if (accept) begin
`ifdef ALU_SEQ_PIPE_EN
            fwd_a <= (state == S_WB) && (instr.instr_srca == dst_q);
            fwd_b <= (state == S_WB) && (instr.instr_srcb == dst_q);
`else
            fwd_a <= 1'b0;
            fwd_b <= 1'b0;
`endif
        end
    end

    // The ALU holds its last result until enabled again, so alu_rezult still
    // carries the retired value during the following ISSUE cycle.
    assign opnd_a = fwd_a ? alu_rezult : ra_data;
    assign opnd_b = fwd_b ? alu_rezult : rb_data;

    // ALU bus is quiet outside ISSUE; op bits are swapped onto the ALU pins
    assign alu_a       = issue ? opnd_a : '0;
    assign alu_b       = issue ? opnd_b : '0;
    assign alu_op_bit0 = issue & op_q[1];
    assign alu_op_bit1 = issue & op_q[0];

    // Flags follow the last committed instruction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (done) begin
            flag_c <= alu_carry;
            flag_z <= alu_z;
        end
    end

    alu_seq_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .AW    (AW)
    ) u_regfile (
        .clock   (clock),
        .reset_n (reset_n),
        .ra_addr (srca_q),
        .ra_data (ra_data),
        .rb_addr (srcb_q),
        .rb_data (rb_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wb_en   (done),
        .wb_addr (dst_q),
        .wb_data (alu_rezult),
        .ld_en   (ld_valid),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: emulates the external registered 4-bit ALU and
// checks directed scenarios plus randomized instruction streams against a
// behavioural register-file model. Build with ALU_SEQ_PIPE_EN to add the
// back-to-back pipelined scenario.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int WIDTH = 4;
    localparam int NREG  = 4;
    localparam int AW    = 2;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             ld_valid = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [WIDTH-1:0] ld_data = '0;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic             alu_enable, alu_op_bit0, alu_op_bit1;
    logic [WIDTH-1:0] alu_rezult = '0;
    logic             alu_carry = 1'b0;
    logic             alu_z = 1'b0;
    logic             done, flag_c, flag_z;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;

    alu_seq_if #(.AW(AW)) ifc ();

    alu_sequencer #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr       (ifc),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_enable  (alu_enable),
        .alu_op_bit0 (alu_op_bit0),
        .alu_op_bit1 (alu_op_bit1),
        .alu_rezult  (alu_rezult),
        .alu_carry   (alu_carry),
        .alu_z       (alu_z),
        .done        (done),
        .flag_c      (flag_c),
        .flag_z      (flag_z),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    always #5 clock = ~clock;

    // External registered ALU: {operation_bit0, operation_bit1} rebuilds the opcode
    always @(posedge clock) begin : alu_emul
        logic [4:0] s;
        if (alu_enable) begin
            case ({alu_op_bit0, alu_op_bit1})
                2'b00:   s = {1'b0, alu_a} + {1'b0, alu_b};
                2'b01:   s = {1'b0, alu_a} - {1'b0, alu_b};
                2'b10:   s = {1'b0, alu_a & alu_b};
                default: s = {1'b0, alu_a | alu_b};
            endcase
            alu_rezult <= s[3:0];
            alu_carry  <= s[4];
            alu_z      <= (s[3:0] == 4'd0);
        end
    end

    int checks = 0;
    int errors = 0;
    int ref_reg [NREG];
    bit ref_c;
    bit ref_z;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input int a, output logic [WIDTH-1:0] d);
        rd_addr = AW'(a);
        #1;
        d = rd_data;
    endtask

    task automatic zero_model();
        for (int i = 0; i < NREG; i++) ref_reg[i] = 0;
        ref_c = 1'b0;
        ref_z = 1'b0;
    endtask

    task automatic do_load(input int a, input int d);
        tick();
        ld_valid = 1'b1;
        ld_addr  = AW'(a);
        ld_data  = WIDTH'(d);
        tick();
        ld_valid = 1'b0;
        ref_reg[a] = d;
    endtask

    // Architectural result of one instruction from integer arithmetic
    task automatic ref_exec(input int op, input int a, input int b, output int r, output bit c);
        case (op)
            0: begin r = (a + b) % 16; c = (a + b) > 15; end
            1: begin r = (a - b + 16) % 16; c = (a < b); end
            2: begin r = a & b; c = 1'b0; end
            default: begin r = a | b; c = 1'b0; end
        endcase
    endtask

    // Offer one instruction, optionally loading in its ISSUE and WB cycles
    task automatic run_instr(input int op, input int a, input int b, input int d,
                             input bit il, input int ila, input int ild,
                             input bit wl, input int wla, input int wld,
                             output bit d_iss, output bit d_wb, output bit tmo);
        int n;
        int r;
        bit c;
        n = 0;
        tick();
        while (!ifc.instr_ready && n < 10) begin
            tick();
            n++;
        end
        tmo = (n >= 10);
        ifc.instr_valid = 1'b1;
        ifc.instr_op    = 2'(op);
        ifc.instr_srca  = AW'(a);
        ifc.instr_srcb  = AW'(b);
        ifc.instr_dst   = AW'(d);
        ref_exec(op, ref_reg[a], ref_reg[b], r, c);
        tick();
        ifc.instr_valid = 1'b0;
        d_iss = done;
        if (il) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(ila);
            ld_data  = WIDTH'(ild);
        end
        tick();
        ld_valid = 1'b0;
        d_wb = done;
        if (wl) begin
            ld_valid = 1'b1;
            ld_addr  = AW'(wla);
            ld_data  = WIDTH'(wld);
        end
        tick();
        ld_valid = 1'b0;
        if (il) ref_reg[ila] = ild;
        if (wl) ref_reg[wla] = wld;
        ref_reg[d] = r;
        ref_c = c;
        ref_z = (r == 0);
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] v;
        #2 reset_n = 1'b0;
        #2;
        checks++; if (ifc.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ifc.instr_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (alu_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", alu_enable); end
        checks++; if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {flag_c, flag_z}); end
        for (int i = 0; i < NREG; i++) begin
            peek(i, v);
            checks++; if (v !== 4'd0) begin errors++; $display("FAIL reset_reg%0d got %0h exp 0", i, v); end
        end
        tick();
        reset_n = 1'b1;
        zero_model();
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] v;
        bit di, dw, tm;
        do_load(0, 5);
        do_load(1, 3);
        run_instr(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, di, dw, tm);
        checks++; if ({tm, di, dw} !== 3'b001) begin errors++; $display("FAIL add_timing got tmo/iss/wb=%b exp 001", {tm, di, dw}); end
        peek(2, v);
        checks++; if (v !== 4'b1000) begin errors++; $display("FAIL add_r2 got %b exp 1000", v); end
        checks++; if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL add_flags got %b exp 00", {flag_c, flag_z}); end
    endtask

    task automatic test_sub();
        logic [WIDTH-1:0] v;
        bit di, dw, tm;
        run_instr(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, di, dw, tm);
        peek(3, v);
        checks++; if (v !== 4'b1110) begin errors++; $display("FAIL sub_borrow_r3 got %b exp 1110", v); end
        checks++; if ({flag_c, flag_z} !== 2'b10) begin errors++; $display("FAIL sub_borrow_flags got %b exp 10", {flag_c, flag_z}); end
        run_instr(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, di, dw, tm);
        peek(3, v);
        checks++; if (v !== 4'b0000) begin errors++; $display("FAIL sub_zero_r3 got %b exp 0000", v); end
        checks++; if ({flag_c, flag_z} !== 2'b01) begin errors++; $display("FAIL sub_zero_flags got %b exp 01", {flag_c, flag_z}); end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] v;
        bit di, dw, tm;
        do_load(0, 15);
        do_load(1, 1);
        run_instr(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, di, dw, tm);
        peek(2, v);
        checks++; if (v !== 4'b0000) begin errors++; $display("FAIL wrap_r2 got %b exp 0000", v); end
        checks++; if ({flag_c, flag_z} !== 2'b11) begin errors++; $display("FAIL wrap_flags got %b exp 11", {flag_c, flag_z}); end
        run_instr(2, 0, 1, 2, 0, 0, 0, 0, 0, 0, di, dw, tm);
        peek(2, v);
        checks++; if (v !== 4'b0001) begin errors++; $display("FAIL and_r2 got %b exp 0001", v); end
        checks++; if ({flag_c, flag_z} !== 2'b00) begin errors++; $display("FAIL and_flags got %b exp 00", {flag_c, flag_z}); end
    endtask

    task automatic test_issue_bus();
        logic [WIDTH-1:0] v;
        do_load(0, 9);
        do_load(1, 6);
        tick();
        checks++; if ({alu_enable, alu_a, alu_b} !== 9'd0) begin errors++; $display("FAIL idle_bus got %h exp 0", {alu_enable, alu_a, alu_b}); end
        ifc.instr_valid = 1'b1;
        ifc.instr_op    = OP_SUB;
        ifc.instr_srca  = 2'd0;
        ifc.instr_srcb  = 2'd1;
        ifc.instr_dst   = 2'd3;
        tick();
        ifc.instr_valid = 1'b0;
        ld_valid = 1'b1;
        ld_addr  = 2'd0;
        ld_data  = 4'hA;
        checks++; if (alu_enable !== 1'b1) begin errors++; $display("FAIL issue_enable got %b exp 1", alu_enable); end
        checks++; if ({alu_a, alu_b} !== 8'h96) begin errors++; $display("FAIL issue_operands got %h exp 96", {alu_a, alu_b}); end
        checks++; if ({alu_op_bit0, alu_op_bit1} !== 2'b01) begin errors++; $display("FAIL issue_opbits got %b exp 01", {alu_op_bit0, alu_op_bit1}); end
        tick();
        ld_valid = 1'b0;
        checks++; if ({alu_enable, alu_a, alu_b, alu_op_bit0, alu_op_bit1} !== 11'd0) begin errors++; $display("FAIL wb_bus got %h exp 0", {alu_enable, alu_a, alu_b, alu_op_bit0, alu_op_bit1}); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL wb_done got %b exp 1", done); end
`ifdef ALU_SEQ_PIPE_EN
        checks++; if (ifc.instr_ready !== 1'b1) begin errors++; $display("FAIL wb_ready got %b exp 1", ifc.instr_ready); end
`else
        checks++; if (ifc.instr_ready !== 1'b0) begin errors++; $display("FAIL wb_ready got %b exp 0", ifc.instr_ready); end
`endif
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done); end
        peek(3, v);
        checks++; if (v !== 4'd3) begin errors++; $display("FAIL issue_load_unseen_r3 got %0d exp 3", v); end
        peek(0, v);
        checks++; if (v !== 4'hA) begin errors++; $display("FAIL issue_load_r0 got %h exp a", v); end
        ref_reg[0] = 10;
        ref_reg[3] = 3;
        ref_c = 1'b0;
        ref_z = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] v;
        bit seen;
        do_load(0, 5);
        do_load(1, 3);
        tick();
        ifc.instr_valid = 1'b1;
        ifc.instr_op    = OP_ADD;
        ifc.instr_srca  = 2'd0;
        ifc.instr_srcb  = 2'd1;
        ifc.instr_dst   = 2'd2;
        tick();
        ifc.instr_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++; if ({alu_enable, done, ifc.instr_ready} !== 3'b001) begin errors++; $display("FAIL midrst_ctrl got %b exp 001", {alu_enable, done, ifc.instr_ready}); end
        tick();
        reset_n = 1'b1;
        zero_model();
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen |= done;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b exp 0", seen); end
        peek(2, v);
        checks++; if (v !== 4'd0) begin errors++; $display("FAIL midrst_r2 got %0h exp 0", v); end
        checks++; if ({flag_c, flag_z, ifc.instr_ready} !== 3'b001) begin errors++; $display("FAIL midrst_idle got %b exp 001", {flag_c, flag_z, ifc.instr_ready}); end
    endtask

    task automatic test_wb_load();
        logic [WIDTH-1:0] v;
        bit di, dw, tm;
        do_load(0, 2);
        do_load(1, 3);
        run_instr(0, 0, 1, 2, 0, 0, 0, 1, 2, 7, di, dw, tm);
        peek(2, v);
        checks++; if (v !== 4'd5) begin errors++; $display("FAIL wbld_same_r2 got %0d exp 5", v); end
        run_instr(3, 0, 1, 3, 0, 0, 0, 1, 1, 9, di, dw, tm);
        peek(3, v);
        checks++; if (v !== 4'd3) begin errors++; $display("FAIL wbld_other_r3 got %0d exp 3", v); end
        peek(1, v);
        checks++; if (v !== 4'd9) begin errors++; $display("FAIL wbld_other_r1 got %0d exp 9", v); end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] v;
        bit di, dw, tm, il, wl;
        int op, a, b, d, ila, ild, wla, wld;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, 3), $urandom_range(0, 15));
            op  = $urandom_range(0, 3);
            a   = $urandom_range(0, 3);
            b   = $urandom_range(0, 3);
            d   = $urandom_range(0, 3);
            il  = ($urandom_range(0, 2) == 0);
            ila = $urandom_range(0, 3);
            ild = $urandom_range(0, 15);
            wl  = ($urandom_range(0, 2) == 0);
            wla = $urandom_range(0, 3);
            wld = $urandom_range(0, 15);
            run_instr(op, a, b, d, il, ila, ild, wl, wla, wld, di, dw, tm);
            checks++; if ({tm, di, dw} !== 3'b001) begin errors++; $display("FAIL rand_timing it=%0d got %b exp 001", it, {tm, di, dw}); end
            checks++; if ({flag_c, flag_z} !== {ref_c, ref_z}) begin errors++; $display("FAIL rand_flags it=%0d got %b exp %b", it, {flag_c, flag_z}, {ref_c, ref_z}); end
            for (int i = 0; i < NREG; i++) begin
                peek(i, v);
                checks++; if (v !== WIDTH'(ref_reg[i])) begin errors++; $display("FAIL rand_reg it=%0d r%0d got %0h exp %0h", it, i, v, ref_reg[i]); end
            end
        end
    endtask

`ifdef ALU_SEQ_PIPE_EN
    task automatic test_back_to_back();
        logic [WIDTH-1:0] v;
        do_load(0, 1);
        tick();
        ifc.instr_valid = 1'b1;
        ifc.instr_op    = OP_ADD;
        ifc.instr_srca  = 2'd0;
        ifc.instr_srcb  = 2'd0;
        ifc.instr_dst   = 2'd1;
        tick();
        ifc.instr_valid = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done0 got %b exp 0", done); end
        tick();
        checks++; if ({done, ifc.instr_ready} !== 2'b11) begin errors++; $display("FAIL b2b_wb1 got %b exp 11", {done, ifc.instr_ready}); end
        ifc.instr_valid = 1'b1;
        ifc.instr_srca  = 2'd1;
        ifc.instr_srcb  = 2'd1;
        ifc.instr_dst   = 2'd2;
        tick();
        ifc.instr_valid = 1'b0;
        checks++; if ({done, alu_enable} !== 2'b01) begin errors++; $display("FAIL b2b_issue2 got %b exp 01", {done, alu_enable}); end
        checks++; if ({alu_a, alu_b} !== 8'h22) begin errors++; $display("FAIL b2b_fwd got %h exp 22", {alu_a, alu_b}); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", done); end
        tick();
        peek(2, v);
        checks++; if (v !== 4'b0100) begin errors++; $display("FAIL b2b_r2 got %b exp 0100", v); end
        ref_reg[1] = 2;
        ref_reg[2] = 4;
        ref_c = 1'b0;
        ref_z = 1'b0;
    endtask
`endif

    initial begin
        ifc.instr_valid = 1'b0;
        ifc.instr_op    = 2'd0;
        ifc.instr_srca  = '0;
        ifc.instr_srcb  = '0;
        ifc.instr_dst   = '0;
        zero_model();
        test_reset();
        test_add();
        test_sub();
        test_wrap();
        test_issue_bus();
        test_reset_mid();
        test_wb_load();
`ifdef ALU_SEQ_PIPE_EN
        test_back_to_back();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
